bldc_speed_ctrl: RTL

Parametrised single-motor speed controller: debounced quadrature encoder front end, signed position counter, period-based speed measurement with stall detection, saturating PI loop, and a two-output H-bridge PWM stage with dead time and brake. Sits between the motor-driver pins and the host register file. It is the next-generation drive core, adding selectable modes, direction command, error counting and glitch-free duty update.

---
 rtl/bldc_pkg.sv | 51 +++++
 rtl/bldc_if.sv | 36 +++
 rtl/bldc_enc_frontend.sv | 97 +++++++++
 rtl/bldc_speed_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC speed controller.
// Holds the mode encoding, the quadrature step decoder and the saturating
// error-counter increment used by the encoder front end.
package bldc_pkg;

  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_OPEN   = 2'b01,
    MODE_CLOSED = 2'b10,
    MODE_BRAKE  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  // Forward Gray successor: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    logic [1:0] nxt;
    nxt = 2'b00;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Classify a transition of the filtered {A,B} pair
  function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] curr);
    step_e s;
    s = STEP_NONE;
    if (prev != curr) begin
      if ((prev ^ curr) == 2'b11)        s = STEP_ILLEGAL;
      else if (gray_next(prev) == curr)  s = STEP_FWD;
      else                               s = STEP_REV;
    end
    return s;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc8(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/bldc_if.sv
// Pin and register bundle of the BLDC speed controller.
// master: host / motor-pin side (drives encoder, mode, setpoints and gains).
// slave : controller side (drives bridge outputs and measurements).
interface bldc_if
  import bldc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  enc_a;
  logic                  enc_b;
  logic [1:0]            mode;
  logic                  dir_cmd;
  logic [DATA_WIDTH-1:0] pwm_period;
  logic [DATA_WIDTH-1:0] period_ref;
  logic [DATA_WIDTH-1:0] duty_ext;
  logic [DATA_WIDTH-1:0] kp;
  logic [DATA_WIDTH-1:0] ki;
  logic                  motor_pos;
  logic                  motor_neg;
  logic [DATA_WIDTH-1:0] period_meas;
  logic [DATA_WIDTH-1:0] pos_count;
  logic                  enc_dir;
  logic [ERR_W-1:0]      enc_err;
  logic                  stalled;
  logic [DATA_WIDTH-1:0] duty;

  modport master (
    output enc_a, enc_b, mode, dir_cmd, pwm_period, period_ref, duty_ext, kp, ki,
    input  motor_pos, motor_neg, period_meas, pos_count, enc_dir, enc_err, stalled, duty
  );

  modport slave (
    input  enc_a, enc_b, mode, dir_cmd, pwm_period, period_ref, duty_ext, kp, ki,
    output motor_pos, motor_neg, period_meas, pos_count, enc_dir, enc_err, stalled, duty
  );
endinterface

// File: rtl/bldc_enc_frontend.sv
// Quadrature encoder front end: debounce, Gray decode, signed position,
// A-period measurement and stall flag.
// Ports: clk, reset (async, active-high), enc_a/enc_b raw inputs;
// period_meas, pos_count, enc_dir, enc_err, stalled registered outputs.
module bldc_enc_frontend
  import bldc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEBOUNCE   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enc_a,
  input  logic                  enc_b,
  output logic [DATA_WIDTH-1:0] period_meas,
  output logic [DATA_WIDTH-1:0] pos_count,
  output logic                  enc_dir,
  output logic [ERR_W-1:0]      enc_err,
  output logic                  stalled
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic [DEBOUNCE-1:0]   sh_a;
  logic [DEBOUNCE-1:0]   sh_b;
  logic                  filt_a;
  logic                  filt_b;
  logic [1:0]            prev_ab;
  logic [DATA_WIDTH-1:0] per_cnt;
  step_e                 step_c;
  logic                  rise_c;

  always_comb begin
    step_c = gray_step(prev_ab, {filt_a, filt_b});
    rise_c = filt_a & ~prev_ab[1];
  end

  // Filtered level changes only once every stored sample agrees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      filt_a <= 1'b0;
      filt_b <= 1'b0;
    end else begin
      sh_a <= {sh_a[DEBOUNCE-2:0], enc_a};
      sh_b <= {sh_b[DEBOUNCE-2:0], enc_b};
      if (&sh_a)       filt_a <= 1'b1;
      else if (~|sh_a) filt_a <= 1'b0;
      if (&sh_b)       filt_b <= 1'b1;
      else if (~|sh_b) filt_b <= 1'b0;
    end
  end

  // Step decode and position tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ab   <= 2'b00;
      pos_count <= '0;
      enc_dir   <= 1'b0;
      enc_err   <= '0;
    end else begin
      prev_ab <= {filt_a, filt_b};
      case (step_c)
        STEP_FWD: begin
          pos_count <= pos_count + DATA_WIDTH'(1);
          enc_dir   <= 1'b1;
        end
        STEP_REV: begin
          pos_count <= pos_count - DATA_WIDTH'(1);
          enc_dir   <= 1'b0;
        end
        STEP_ILLEGAL: enc_err <= sat_inc8(enc_err);
        default: ;
      endcase
    end
  end

  // Counts clk cycles between filtered A rising edges; pins at all-ones on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt     <= '0;
      period_meas <= '0;
      stalled     <= 1'b0;
    end else if (rise_c) begin
      period_meas <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + DATA_WIDTH'(1);
      per_cnt     <= '0;
      stalled     <= 1'b0;
    end else if (per_cnt == CNT_MAX) begin
      period_meas <= CNT_MAX;
      stalled     <= 1'b1;
    end else begin
      per_cnt <= per_cnt + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bldc_speed_ctrl.sv
// BLDC speed controller top: encoder front end, 3-stage PI loop, frame-
// synchronous duty update, PWM with dead time and brake.
// Ports: clk, reset (async, active-high), bus (bldc_if.slave) carrying the
// encoder inputs, mode/direction/setpoints/gains and all measured outputs.
module bldc_speed_ctrl
  import bldc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned INT_LIMIT  = 2047,
  parameter int unsigned GAIN_SHIFT = 4,
  parameter int unsigned DEADTIME   = 4
) (
  input logic   clk,
  input logic   reset,
  bldc_if.slave bus
);

  localparam int unsigned EW  = DATA_WIDTH + 1;
  localparam int unsigned IW  = DATA_WIDTH + 2;
  localparam int unsigned SW  = 2 * DATA_WIDTH + 2;
  localparam int unsigned DTW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic signed [EW-1:0] INT_MAX = EW'(INT_LIMIT);
  localparam logic signed [EW-1:0] INT_MIN = -INT_MAX;

  logic [DATA_WIDTH-1:0] period_meas;
  mode_e                 mode_c;
  logic                  drive_c;
  logic [DATA_WIDTH-1:0] pwm_cnt;
  logic                  frame_start_c;
  logic signed [EW-1:0]  err_c, err_r, integ, integ_next_c;
  logic signed [IW-1:0]  integ_sum_c;
  logic signed [SW-1:0]  sum_c, shifted_c;
  logic [DATA_WIDTH-1:0] pi_clamp_c, pi_res, shadow;
  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] duty_src_c, duty_eff_c, duty_r;
  logic                  pwm_c;
  logic                  dir_q;
  logic [DTW-1:0]        dt_cnt;
  logic                  dir_change_c, in_dt_c;

  bldc_enc_frontend #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEBOUNCE  (DEBOUNCE)
  ) u_frontend (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (bus.enc_a),
    .enc_b      (bus.enc_b),
    .period_meas(period_meas),
    .pos_count  (bus.pos_count),
    .enc_dir    (bus.enc_dir),
    .enc_err    (bus.enc_err),
    .stalled    (bus.stalled)
  );

  assign bus.period_meas = period_meas;
  assign bus.duty        = duty_r;

  // PI arithmetic, duty selection and pwm compare
  always_comb begin
    mode_c        = mode_e'(bus.mode);
    drive_c       = (mode_c == MODE_OPEN) || (mode_c == MODE_CLOSED);
    frame_start_c = (pwm_cnt == '0);
    err_c         = signed'({1'b0, period_meas}) - signed'({1'b0, bus.period_ref});
    integ_sum_c   = IW'(integ) + IW'(err_c);
    integ_next_c  = EW'(integ_sum_c);
    if (integ_sum_c > IW'(INT_MAX))      integ_next_c = INT_MAX;
    else if (integ_sum_c < IW'(INT_MIN)) integ_next_c = INT_MIN;
    sum_c = signed'(SW'(bus.kp)) * SW'(err_r) + signed'(SW'(bus.ki)) * SW'(integ);
    shifted_c  = sum_c >>> GAIN_SHIFT;
    pi_clamp_c = shifted_c[DATA_WIDTH-1:0];
    if (shifted_c[SW-1])                                  pi_clamp_c = '0;
    else if (shifted_c > signed'(SW'(bus.pwm_period)))    pi_clamp_c = bus.pwm_period;
    duty_src_c = '0;
    case (mode_c)
      MODE_OPEN:   duty_src_c = (bus.duty_ext > bus.pwm_period) ? bus.pwm_period : bus.duty_ext;
      MODE_CLOSED: duty_src_c = shadow;
      default:     duty_src_c = '0;
    endcase
    // The frame's first cycle already compares against the duty being loaded
    duty_eff_c   = frame_start_c ? duty_src_c : duty_r;
    pwm_c        = (bus.pwm_period != '0) && (pwm_cnt < duty_eff_c);
    dir_change_c = drive_c && (bus.dir_cmd != dir_q);
    in_dt_c      = dir_change_c || (dt_cnt != '0);
  end

  // PWM frame counter and frame-synchronous duty register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
    end else begin
      if (bus.pwm_period == '0 || pwm_cnt >= bus.pwm_period) pwm_cnt <= '0;
      else                                                   pwm_cnt <= pwm_cnt + DATA_WIDTH'(1);
      if (frame_start_c) duty_r <= duty_src_c;
    end
  end

  // PI pipeline: integrate, scale/clamp, publish to shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; err_r <= '0; integ <= '0; pi_res <= '0; shadow <= '0;
    end else if (mode_c == MODE_OFF) begin
      v1 <= 1'b0; v2 <= 1'b0; err_r <= '0; integ <= '0; pi_res <= '0; shadow <= '0;
    end else begin
      v1 <= frame_start_c && (mode_c == MODE_CLOSED);
      v2 <= v1;
      if (frame_start_c && (mode_c == MODE_CLOSED)) begin
        err_r <= err_c;
        integ <= integ_next_c;
      end
      if (v1) pi_res <= pi_clamp_c;
      if (v2) shadow <= pi_res;
    end
  end

  // Dead time: the change cycle plus DEADTIME-1 counted cycles hold both sides low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q  <= 1'b0;
      dt_cnt <= '0;
    end else begin
      dir_q <= bus.dir_cmd;
      if (dir_change_c)        dt_cnt <= DTW'(DEADTIME - 1);
      else if (dt_cnt != '0)   dt_cnt <= dt_cnt - DTW'(1);
    end
  end

  // Registered bridge outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.motor_pos <= 1'b0;
      bus.motor_neg <= 1'b0;
    end else begin
      case (mode_c)
        MODE_BRAKE: begin
          bus.motor_pos <= 1'b1;
          bus.motor_neg <= 1'b1;
        end
        MODE_OPEN, MODE_CLOSED: begin
          bus.motor_pos <= !in_dt_c && pwm_c && !bus.dir_cmd;
          bus.motor_neg <= !in_dt_c && pwm_c && bus.dir_cmd;
        end
        default: begin
          bus.motor_pos <= 1'b0;
          bus.motor_neg <= 1'b0;
        end
      endcase
    end
  end

endmodule
